// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory-port arbiter.
//   arb_state_e : two-state transaction FSM encoding (ARB_IDLE, ARB_BUSY)
//   LEN_*       : transfer-length codes, identical to the memory-controller encoding
package mem_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  localparam int unsigned LEN_BYTE = 1;
  localparam int unsigned LEN_HALF = 2;
  localparam int unsigned LEN_WORD = 4;

endpackage

// File: rtl/arb_picker.sv
// Combinational winner select for the memory-port arbiter.
// Build option ARB_ROUND_ROBIN_EN: when defined, the search starts at rr_ptr and
// wraps mod NUM_CH; otherwise fixed priority with index 0 highest.
// Ports:
//   req_valid  in   per-channel request level
//   rr_ptr     in   round-robin search start (only with ARB_ROUND_ROBIN_EN)
//   grant_oh   out  one-hot winner (all zero when nothing is valid)
//   grant_idx  out  binary winner index
//   grant_any  out  at least one channel is requesting
module arb_picker #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_valid,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic [CH_W-1:0]   rr_ptr,
`endif
  output logic [NUM_CH-1:0] grant_oh,
  output logic [CH_W-1:0]   grant_idx,
  output logic              grant_any
);

`ifdef ARB_ROUND_ROBIN_EN
  logic [CH_W-1:0] cand;

  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      cand = CH_W'((32'(rr_ptr) + k) % NUM_CH);
      if (!grant_any && req_valid[cand]) begin
        grant_any       = 1'b1;
        grant_oh[cand]  = 1'b1;
        grant_idx       = cand;
      end
    end
  end
`else
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!grant_any && req_valid[i]) begin
        grant_any   = 1'b1;
        grant_oh[i] = 1'b1;
        grant_idx   = CH_W'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// N-channel arbiter in front of the single byte-serial memory controller.
// Latches one request per transaction into the mc_* command registers, returns
// completion/read data to the owning channel, and handles pipeline flush: an
// in-flight read is aborted, an in-flight write always completes.
// Build option ARB_ROUND_ROBIN_EN: round-robin arbitration with an rr_ptr
// register; when undefined, fixed priority (index 0 highest), no rr_ptr.
// Ports:
//   clk_in, rst_in          clock, asynchronous active-high reset
//   rdy_in                  global ready; all state frozen while low
//   flush                   pipeline clear
//   req_valid/wr/len/addr/wdata  per-channel request, packed by channel
//   resp_done, resp_data    one-hot completion pulse and shared read data
//   busy                    transaction outstanding
//   mc_req/wr/len/addr/wdata latched command to the memory controller
//   mc_abort                one-cycle abort of an in-flight read
//   mc_ready, mc_rdata      memory-controller completion and read result
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 3,
  parameter int unsigned CH_W   = $clog2(NUM_CH)
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     flush,
  input  logic [NUM_CH-1:0]        req_valid,
  input  logic [NUM_CH-1:0]        req_wr,
  input  logic [NUM_CH*LEN_W-1:0]  req_len,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  input  logic [NUM_CH*DATA_W-1:0] req_wdata,
  output logic [NUM_CH-1:0]        resp_done,
  output logic [DATA_W-1:0]        resp_data,
  output logic                     busy,
  output logic                     mc_req,
  output logic                     mc_wr,
  output logic [LEN_W-1:0]         mc_len,
  output logic [ADDR_W-1:0]        mc_addr,
  output logic [DATA_W-1:0]        mc_wdata,
  output logic                     mc_abort,
  input  logic                     mc_ready,
  input  logic [DATA_W-1:0]        mc_rdata
);

  arb_state_e state_q, state_d;

  logic              mc_req_q,   mc_req_d;
  logic              mc_wr_q,    mc_wr_d;
  logic [LEN_W-1:0]  mc_len_q,   mc_len_d;
  logic [ADDR_W-1:0] mc_addr_q,  mc_addr_d;
  logic [DATA_W-1:0] mc_wdata_q, mc_wdata_d;
  logic [CH_W-1:0]   owner_q,    owner_d;

  logic [NUM_CH-1:0] grant_oh;
  logic [CH_W-1:0]   grant_idx;
  logic              grant_any;

  logic              st_busy;
  logic              grant;
  logic              abort;
  logic              complete;

  logic              sel_wr;
  logic [LEN_W-1:0]  sel_len;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

`ifdef ARB_ROUND_ROBIN_EN
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
`endif

  arb_picker #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_picker (
    .req_valid (req_valid),
`ifdef ARB_ROUND_ROBIN_EN
    .rr_ptr    (rr_ptr_q),
`endif
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // One-hot request mux for the winning channel's fields.
  always_comb begin
    sel_wr    = 1'b0;
    sel_len   = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_oh[i]) begin
        sel_wr    = req_wr[i];
        sel_len   = req_len[i*LEN_W +: LEN_W];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= ARB_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: if (grant)             state_d = ARB_BUSY;
      ARB_BUSY: if (complete || abort) state_d = ARB_IDLE;
      default:                         state_d = ARB_IDLE;
    endcase
  end

  // FSM: outputs and transaction strobes. Everything is gated by rdy_in so a
  // low rdy_in freezes the block. A flush only aborts reads; writes run on.
  always_comb begin
    st_busy   = (state_q == ARB_BUSY);
    grant     = rdy_in && !flush && !st_busy && grant_any;
    abort     = rdy_in && st_busy && flush && !mc_wr_q;
    complete  = rdy_in && st_busy && mc_ready && !abort;
    busy      = st_busy;
    mc_abort  = abort;
    resp_done = complete ? ({{(NUM_CH-1){1'b0}}, 1'b1} << owner_q) : '0;
  end

  assign resp_data = mc_rdata;

  // Command/owner registers
  always_comb begin
    mc_req_d   = mc_req_q;
    mc_wr_d    = mc_wr_q;
    mc_len_d   = mc_len_q;
    mc_addr_d  = mc_addr_q;
    mc_wdata_d = mc_wdata_q;
    owner_d    = owner_q;
    if (grant) begin
      mc_req_d   = 1'b1;
      mc_wr_d    = sel_wr;
      mc_len_d   = sel_len;
      mc_addr_d  = sel_addr;
      mc_wdata_d = sel_wdata;
      owner_d    = grant_idx;
    end else if (complete || abort) begin
      mc_req_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mc_req_q   <= 1'b0;
      mc_wr_q    <= 1'b0;
      mc_len_q   <= '0;
      mc_addr_q  <= '0;
      mc_wdata_q <= '0;
      owner_q    <= '0;
    end else begin
      mc_req_q   <= mc_req_d;
      mc_wr_q    <= mc_wr_d;
      mc_len_q   <= mc_len_d;
      mc_addr_q  <= mc_addr_d;
      mc_wdata_q <= mc_wdata_d;
      owner_q    <= owner_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Pointer advances past the winner on every grant; flush does not touch it.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant) begin
      rr_ptr_d = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end
`endif

  assign mc_req   = mc_req_q;
  assign mc_wr    = mc_wr_q;
  assign mc_len   = mc_len_q;
  assign mc_addr  = mc_addr_q;
  assign mc_wdata = mc_wdata_q;

endmodule
